// File: rtl/clb_cfg_pkg.sv
// Shared definitions for the CLB configuration loader: frame width, preamble,
// field positions inside a CLB configuration word and the loader FSM states.
package clb_cfg_pkg;

    localparam int CLB_CFG_W = 37;
    localparam logic [3:0] PREAMBLE = 4'b0010;

    // Field positions inside the 37-bit CLB configuration word
    localparam int MEM_LSB   = 0;   // LUT contents
    localparam int MEM_MSB   = 15;
    localparam int COMB_LSB  = 16;  // combination mode
    localparam int COMB_MSB  = 17;
    localparam int MUX2_LSB  = 18;
    localparam int MUX2_MSB  = 19;
    localparam int MUX3_LSB  = 20;
    localparam int MUX3_MSB  = 21;
    localparam int MUX4_LSB  = 22;
    localparam int MUX4_MSB  = 23;
    localparam int MUX5_LSB  = 24;
    localparam int MUX5_MSB  = 25;
    localparam int MUX6_LSB  = 26;
    localparam int MUX6_MSB  = 27;
    localparam int O2M0_LSB  = 28;  // {o2m3_0, o2m2_0, o2m1_0}
    localparam int O2M0_MSB  = 30;
    localparam int O2M1_LSB  = 31;  // {o2m3_1, o2m2_1, o2m1_1}
    localparam int O2M1_MSB  = 33;
    localparam int DQMUX_LSB = 34;  // {DQmux2, DQmux1}
    localparam int DQMUX_MSB = 35;
    localparam int FOL_BIT   = 36;  // flop/latch select

    typedef enum logic [3:0] {
        ST_HUNT  = 4'd0,
        ST_COUNT = 4'd1,
        ST_START = 4'd2,
        ST_DATA  = 4'd3,
        ST_PAR   = 4'd4,
        ST_STOP  = 4'd5,
        ST_WRITE = 4'd6,
        ST_DONE  = 4'd7,
        ST_ERROR = 4'd8
    } cfg_state_e;

endpackage

// File: rtl/cfg_shift_par.sv
// Frame shadow register: MSB-first shift register with a running parity bit.
// Clear has priority over shift.
module cfg_shift_par #(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic         i_din,
    output logic [W-1:0] o_word,
    output logic         o_par
);

    // Shift serial bits in and fold each one into the running parity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_word <= '0;
            o_par  <= 1'b0;
        end else if (i_clr) begin
            o_word <= '0;
            o_par  <= 1'b0;
        end else if (i_en) begin
            o_word <= {o_word[W-2:0], i_din};
            o_par  <= o_par ^ i_din;
        end
    end

endmodule

// File: rtl/clb_cfg_loader.sv
// Serial CLB configuration writer: hunts for the preamble, reads the frame
// count, then receives framed, parity-checked 37-bit words and strobes each
// into the CLB configuration store at sequential addresses.
module clb_cfg_loader
    import clb_cfg_pkg::*;
#(
    parameter int FRAME_W = CLB_CFG_W,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din,
    input  logic               din_vld,
    output logic [FRAME_W-1:0] cfg_word,
    output logic [ADDR_W-1:0]  cfg_addr,
    output logic               cfg_we,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int BC_W = $clog2((FRAME_W > CNT_W ? FRAME_W : CNT_W) + 1);
    // Largest frame count that still fits the address space (2**ADDR_W)
    localparam logic [CNT_W:0] N_MAX = (CNT_W+1)'(1) << ADDR_W;

    cfg_state_e         r_state;
    logic [2:0]         r_hunt;
    logic [CNT_W-1:0]   r_n;
    logic [BC_W-1:0]    r_bcnt;
    logic [ADDR_W-1:0]  r_idx;

    logic               w_sh_clr;
    logic               w_sh_en;
    logic [FRAME_W-1:0] w_shadow;
    logic               w_par;
    logic [CNT_W-1:0]   w_n_next;
    logic               w_last_frame;

    // Shadow is discarded on each start bit so a frame always begins clean
    assign w_sh_clr     = (r_state == ST_START) && din_vld && !din;
    assign w_sh_en      = (r_state == ST_DATA) && din_vld;
    assign w_n_next     = {r_n[CNT_W-2:0], din};
    assign w_last_frame = ({{(CNT_W-ADDR_W){1'b0}}, r_idx} == (r_n - 1'b1));

    cfg_shift_par #(.W(FRAME_W)) u_shift (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_sh_clr),
        .i_en   (w_sh_en),
        .i_din  (din),
        .o_word (w_shadow),
        .o_par  (w_par)
    );

    // Loader FSM; every state except WRITE advances only on din_vld cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_HUNT;
            r_hunt   <= 3'b111;
            r_n      <= '0;
            r_bcnt   <= '0;
            r_idx    <= '0;
            cfg_word <= '0;
            cfg_addr <= '0;
            cfg_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            cfg_we <= 1'b0;
            case (r_state)
                ST_HUNT: if (din_vld) begin
                    r_hunt <= {r_hunt[1:0], din};
                    if ({r_hunt, din} == PREAMBLE) begin
                        r_state <= ST_COUNT;
                        r_bcnt  <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_COUNT: if (din_vld) begin
                    r_n    <= w_n_next;
                    r_bcnt <= r_bcnt + 1'b1;
                    if (r_bcnt == BC_W'(CNT_W-1)) begin
                        if (w_n_next == '0) begin
                            r_state <= ST_DONE;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else if ({1'b0, w_n_next} > N_MAX) begin
                            r_state <= ST_ERROR;
                            err     <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            r_state <= ST_START;
                            r_idx   <= '0;
                        end
                    end
                end
                // 1s are padding between frames
                ST_START: if (din_vld && !din) begin
                    r_state <= ST_DATA;
                    r_bcnt  <= '0;
                end
                ST_DATA: if (din_vld) begin
                    r_bcnt <= r_bcnt + 1'b1;
                    if (r_bcnt == BC_W'(FRAME_W-1))
                        r_state <= ST_PAR;
                end
                ST_PAR: if (din_vld) begin
                    if (w_par ^ din) begin
                        r_state <= ST_ERROR;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: if (din_vld) begin
                    if (din) begin
                        r_state <= ST_WRITE;
                    end else begin
                        r_state <= ST_ERROR;
                        err     <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                // Write cycle does not consume a serial bit
                ST_WRITE: begin
                    cfg_word <= w_shadow;
                    cfg_addr <= r_idx;
                    cfg_we   <= 1'b1;
                    if (w_last_frame) begin
                        r_state <= ST_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= ST_START;
                    end
                end
                default: ; // DONE / ERROR: terminal until reset
            endcase
        end
    end

endmodule
